// File: rtl/elastic_pipe_buf_pkg.sv
// Shared constants and helpers for the elastic pipe buffer.
package elastic_pipe_buf_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Pointer width for a store of n entries, never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/elastic_pipe_buf_mem.sv
// Register store behind the head register: one synchronous write port,
// asynchronous read at rd_addr.
module elastic_pipe_buf_mem #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 3,
    parameter int PW      = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [ENTRIES];

    // Write one entry per cycle; contents need no reset because the
    // pointers and count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Oldest stored entry, visible combinationally for head refill.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/elastic_pipe_buf.sv
// Multi-entry valid/ready elastic buffer: a registered head (output) stage
// in front of a circular store of DEPTH-1 entries. s_ready, m_valid, m_data,
// count and almost_full are all registered, so no combinational path
// crosses the block.
//
// Handshake: a beat moves upstream->buffer only when s_valid & s_ready at a
// rising edge, and buffer->downstream only when m_valid & m_ready at a
// rising edge. s_valid may stay high while s_ready is low; nothing is taken.
// Once m_valid is high, m_data holds until the pop, a flush or rst.
module elastic_pipe_buf
    import elastic_pipe_buf_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3,
    localparam int CW          = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int ENTRIES = DEPTH - 1;
    localparam int PW      = ptr_width(ENTRIES);

    logic             push;
    logic             pop;
    logic             store_empty;
    logic             head_take_in;
    logic             store_wr;
    logic             store_rd;
    logic [CW-1:0]    count_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] store_rd_data;

    // Circular pointer advance, wrapping from the last store slot to 0.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshakes and the routing decision for an incoming beat: it lands in
    // the head when the head is (or is becoming) empty with nothing stored,
    // otherwise it goes into the store.
    always_comb begin
        push         = s_valid & s_ready;
        pop          = m_valid & m_ready;
        store_empty  = (count == CW'(m_valid));
        head_take_in = push & (~m_valid | (pop & store_empty));
        store_wr     = push & ~head_take_in & ~flush & ~rst;
        store_rd     = pop & ~store_empty;
        count_next   = count + CW'(push) - CW'(pop);
    end

    elastic_pipe_buf_mem #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .PW      (PW)
    ) u_mem (
        .clk     (clk),
        .we      (store_wr),
        .wr_addr (wr_ptr),
        .wr_data (s_data),
        .rd_addr (rd_ptr),
        .rd_data (store_rd_data)
    );

    // Occupancy, flags, pointers and head register; rst beats flush, and
    // flush drops any coinciding push while leaving m_data untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            s_ready     <= 1'b0;
            almost_full <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (flush) begin
            count       <= '0;
            s_ready     <= 1'b1;
            almost_full <= 1'b0;
            m_valid     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            count       <= count_next;
            s_ready     <= (count_next < CW'(DEPTH));
            almost_full <= (count_next >= CW'(AFULL_THRESH));
            if (store_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (store_rd) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                m_data  <= store_rd_data;
                m_valid <= 1'b1;
            end else if (head_take_in) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
            end else if (pop) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
